// File: rtl/uart_cmd_hub_if.sv
// Byte-stream bundle between the UART instances and uart_cmd_hub.
// master is the UART side (rx bytes, tx_ready); slave is the hub.
interface uart_cmd_hub_if #(
   parameter int UARTS = 2
);
   logic [UARTS-1:0]   rx_valid;
   logic [8*UARTS-1:0] rx_data;
   logic [UARTS-1:0]   tx_ready;
   logic [UARTS-1:0]   tx_send;
   logic [8*UARTS-1:0] tx_data;

   modport master (
      output rx_valid, rx_data, tx_ready,
      input  tx_send, tx_data
   );

   modport slave (
      input  rx_valid, rx_data, tx_ready,
      output tx_send, tx_data
   );
endinterface

// File: rtl/uart_cmd_hub.sv
// Multi-channel UART echo hub with FIFO buffering, LED command decode and heartbeat.
// Optional status reply on '?' enabled by UART_CMD_HUB_STATUS_EN.
module uart_cmd_hub #(
   parameter int UARTS      = 2,
   parameter int LEDS       = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CMD_CHAN   = 0,
   parameter int HB_BITS    = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_cmd_hub_if.slave    bus,
   output logic [LEDS-1:0]  led,
   output logic             heartbeat,
   output logic [UARTS-1:0] overflow
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [HB_BITS-1:0] hb_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hb_cnt <= '0;
      else        hb_cnt <= hb_cnt + HB_BITS'(1);
   end

   assign heartbeat = hb_cnt[HB_BITS-1];

   logic [7:0]      cmd_byte;
   logic            cmd_vld;
   logic [LEDS-1:0] led_nxt;

   assign cmd_byte = bus.rx_data[8*CMD_CHAN +: 8];
   assign cmd_vld  = bus.rx_valid[CMD_CHAN];

   always_comb begin
      led_nxt = led;
      if (cmd_vld) begin
         unique case (1'b1)
            (cmd_byte == 8'h30): led_nxt = '0;
            (cmd_byte == 8'h2A): led_nxt = '1;
            default: begin
               for (int k = 0; k < LEDS; k++)
                  if (cmd_byte == 8'(49 + k))
                     led_nxt[k] = ~led[k];
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led <= '0;
      else        led <= led_nxt;
   end

`ifdef UART_CMD_HUB_STATUS_EN
   logic [3:0] st_led;
   logic [7:0] status_byte;

   for (genvar j = 0; j < 4; j++) begin : g_st
      if (j < LEDS) begin : g_on
         assign st_led[j] = led[j];
      end else begin : g_off
         assign st_led[j] = 1'b0;
      end
   end

   // led here is the pre-update value, so '?' reports the state before this cycle
   assign status_byte = {4'h4, st_led};
`endif

   for (genvar i = 0; i < UARTS; i++) begin : g_ch
      logic [7:0]    mem [FIFO_DEPTH];
      logic [AW-1:0] wr_ptr;
      logic [AW-1:0] rd_ptr;
      logic [CW-1:0] cnt;
      logic [7:0]    in_byte;
      logic [7:0]    txd_q;
      logic          send_q;
      logic          ovf_q;
      logic          push;
      logic          pop;
      logic          full;
      logic          accept;

      always_comb begin
         in_byte = bus.rx_data[8*i +: 8];
`ifdef UART_CMD_HUB_STATUS_EN
         if (i == CMD_CHAN && in_byte == 8'h3F)
            in_byte = status_byte;
`endif
      end

      assign push   = bus.rx_valid[i];
      assign full   = (cnt == CW'(FIFO_DEPTH));
      // send_q gate forces an idle cycle between pulses
      assign pop    = (cnt != '0) && bus.tx_ready[i] && !send_q;
      assign accept = push && (!full || pop);

      always_ff @(posedge clk) begin
         if (accept) mem[wr_ptr] <= in_byte;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            txd_q  <= '0;
            send_q <= 1'b0;
            ovf_q  <= 1'b0;
         end else begin
            send_q <= pop;
            if (pop) begin
               txd_q  <= mem[rd_ptr];
               rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept)
               wr_ptr <= wr_ptr + AW'(1);
            if (push && !accept)
               ovf_q <= 1'b1;
            cnt <= cnt + CW'(accept) - CW'(pop);
         end
      end

      assign bus.tx_send[i]        = send_q;
      assign bus.tx_data[8*i +: 8] = txd_q;
      assign overflow[i]           = ovf_q;
   end
endmodule

// File: tb/tb_uart_cmd_hub.sv
// Scoreboard bench for uart_cmd_hub: echo, overflow, LED commands, reset, status.
// Expected echo bytes are queued at stimulus time and checked by a monitor.
module tb_uart_cmd_hub;
   localparam int UARTS = 2;
   localparam int LEDS  = 4;
   localparam int DEPTH = 4;
   localparam int HB    = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [LEDS-1:0]  led;
   logic             heartbeat;
   logic [UARTS-1:0] overflow;

   uart_cmd_hub_if #(.UARTS(UARTS)) bus ();

   uart_cmd_hub #(
      .UARTS(UARTS), .LEDS(LEDS), .FIFO_DEPTH(DEPTH),
      .CMD_CHAN(0), .HB_BITS(HB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave),
      .led(led), .heartbeat(heartbeat), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int sends0 = 0;
   int sends1 = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [UARTS-1:0] prev_send = '0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_byte(input int ch, input logic [7:0] b);
      if (ch == 0) q0.push_back(b);
      else         q1.push_back(b);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rx(input logic [UARTS-1:0] v, input logic [15:0] d);
      bus.rx_valid = v;
      bus.rx_data  = d;
      tick();
      bus.rx_valid = '0;
      bus.rx_data  = '0;
   endtask

   // monitor: every tx_send pulse pops and compares the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < UARTS; i++) begin
            if (bus.tx_send[i]) begin
               logic [7:0] got;
               logic [7:0] exp;
               got = bus.tx_data[8*i +: 8];
               chk($sformatf("send_gap_ch%0d", i), 32'(prev_send[i]), 0);
               checks++;
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  failures++;
                  $display("FAIL unexpected_send_ch%0d: got %0h expected none", i, got);
               end else begin
                  exp = (i == 0) ? q0.pop_front() : q1.pop_front();
                  checks--;
                  chk($sformatf("echo_ch%0d", i), 32'(got), 32'(exp));
               end
               if (i == 0) sends0++;
               else        sends1++;
            end
         end
         prev_send = bus.tx_send;
      end else begin
         prev_send = '0;
      end
   end

   logic [7:0] t4_bytes [6] = '{8'h31, 8'h33, 8'h33, 8'h34, 8'h2A, 8'h30};
   logic [3:0] t4_led   [6] = '{4'b0001, 4'b0101, 4'b0001, 4'b1001, 4'b1111, 4'b0000};

   initial begin
      int s0;
      int s1;
      logic [7:0] st_exp;
      bus.rx_valid = '0;
      bus.rx_data  = '0;
      bus.tx_ready = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // heartbeat: counter equals k at the negedge after k edges
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         chk("heartbeat", 32'(heartbeat), (k >> 3) & 1);
         chk("idle_outputs", {bus.tx_send, led, overflow}, 0);
      end

      bus.tx_ready = 2'b11;
      tick();

      // simultaneous bytes on both channels, 2-clock latency
      expect_byte(0, 8'h41);
      expect_byte(1, 8'h42);
      rx(2'b11, 16'h4241);
      @(negedge clk);
      chk("t2_not_early", 32'(bus.tx_send), 0);
      @(negedge clk);
      chk("t2_send", 32'(bus.tx_send), 2'b11);
      chk("t2_data", 32'(bus.tx_data), 16'h4241);
      tick();
      repeat (3) tick();

      // fill ch0 with tx blocked, fifth byte dropped
      bus.tx_ready = 2'b10;
      for (int b = 8'h10; b <= 8'h14; b++) begin
         if (b < 8'h14) expect_byte(0, 8'(b));
         rx(2'b01, {8'h00, 8'(b)});
         if (b == 8'h13) chk("t3_no_ovf_yet", 32'(overflow), 0);
      end
      chk("t3_ovf_set", 32'(overflow), 2'b01);
      s0 = sends0;
      bus.tx_ready = 2'b11;
      repeat (7) tick();
      @(negedge clk);
      #1;
      chk("t3_sends_in_7", sends0 - s0, 4);
      chk("t3_q0_drained", q0.size(), 0);
      chk("t3_ovf_sticky", 32'(overflow), 2'b01);
      tick();
      repeat (2) tick();

      // LED commands on ch0, then the same bytes on ch1
      for (int n = 0; n < 6; n++) begin
         expect_byte(0, t4_bytes[n]);
         rx(2'b01, {8'h00, t4_bytes[n]});
         chk($sformatf("t4_led_%0d", n), 32'(led), 32'(t4_led[n]));
         tick();
         tick();
      end
      expect_byte(0, 8'h32);
      rx(2'b01, 16'h0032);
      chk("t4_led_2", 32'(led), 4'b0010);
      tick();
      tick();
      for (int n = 0; n < 6; n++) begin
         expect_byte(1, t4_bytes[n]);
         rx(2'b10, {t4_bytes[n], 8'h00});
         chk("t4_ch1_no_led", 32'(led), 4'b0010);
         tick();
         tick();
      end
      repeat (4) tick();
      chk("t4_drained", q0.size() + q1.size(), 0);

      // reset with bytes buffered on ch0 and a send about to launch on ch1
      bus.tx_ready = 2'b10;
      rx(2'b01, 16'h0055);
      rx(2'b01, 16'h0056);
      rx(2'b01, 16'h0057);
      rx(2'b10, 16'h6600);
      rst_n = 1'b0;
      #1;
      chk("t5_tx_send", 32'(bus.tx_send), 0);
      chk("t5_tx_data", 32'(bus.tx_data), 0);
      chk("t5_led", 32'(led), 0);
      chk("t5_overflow", 32'(overflow), 0);
      chk("t5_heartbeat", 32'(heartbeat), 0);
      q0.delete();
      q1.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus.tx_ready = 2'b11;
      s0 = sends0;
      s1 = sends1;
      tick();
      repeat (10) tick();
      chk("t5_no_send_ch0", sends0 - s0, 0);
      chk("t5_no_send_ch1", sends1 - s1, 0);

      // '?' reply: status byte when enabled, plain echo otherwise
      expect_byte(0, 8'h31);
      rx(2'b01, 16'h0031);
      tick();
      tick();
      expect_byte(0, 8'h33);
      rx(2'b01, 16'h0033);
      tick();
      tick();
      chk("t6_led", 32'(led), 4'b0101);
`ifdef UART_CMD_HUB_STATUS_EN
      st_exp = 8'h45;
`else
      st_exp = 8'h3F;
`endif
      expect_byte(0, st_exp);
      rx(2'b01, 16'h003F);
      chk("t6_led_hold", 32'(led), 4'b0101);
      repeat (6) tick();
      chk("t6_drained", q0.size() + q1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
